// File: rtl/tri_buffer.sv
// Inverting tri-state bus driver with a clocked activity monitor.
// The data path is purely combinational. The monitor counts drive cycles and input toggles for contention debug.
module tri_buffer #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    output tri   [WIDTH-1:0] y,
    input  logic             clk,
    input  logic             rst,
    output logic             drive_active,
    output logic [CNT_W-1:0] en_cycles,
    output logic [CNT_W-1:0] d_toggles
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             drive_active_d, drive_active_q;
    logic [CNT_W-1:0] en_cycles_d, en_cycles_q;
    logic [CNT_W-1:0] d_toggles_d, d_toggles_q;
    logic [WIDTH-1:0] d_prev_d, d_prev_q;

    // Bus driver: an unknown enable merges ~d with Z, which yields X in simulation
    assign y = en ? ~d : {WIDTH{1'bz}};

    // Next-state for the monitor; both counters saturate instead of wrapping
    always_comb begin
        drive_active_d = en;
        d_prev_d       = d;
        en_cycles_d    = en_cycles_q;
        d_toggles_d    = d_toggles_q;
        if (en && (en_cycles_q != CNT_MAX)) begin
            en_cycles_d = en_cycles_q + CNT_ONE;
        end else begin
            en_cycles_d = en_cycles_q;
        end
        if ((d != d_prev_q) && (d_toggles_q != CNT_MAX)) begin
            d_toggles_d = d_toggles_q + CNT_ONE;
        end else begin
            d_toggles_d = d_toggles_q;
        end
    end

    // Monitor state; reset wins and discards any event sampled on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            drive_active_q <= 1'b0;
            en_cycles_q    <= {CNT_W{1'b0}};
            d_toggles_q    <= {CNT_W{1'b0}};
            d_prev_q       <= {WIDTH{1'b0}};
        end else begin
            drive_active_q <= drive_active_d;
            en_cycles_q    <= en_cycles_d;
            d_toggles_q    <= d_toggles_d;
            d_prev_q       <= d_prev_d;
        end
    end

    assign drive_active = drive_active_q;
    assign en_cycles    = en_cycles_q;
    assign d_toggles    = d_toggles_q;

endmodule

// File: tb/tb_tri_buffer.sv
// Bench for tri_buffer: an 8-bit/16-bit-counter instance and a 1-bit/4-bit-counter instance,
// each sharing its bus with a bench-side driver, checked against an event-count model.
module tb_tri_buffer;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] d = 8'h00;

    logic       drv_a_en = 1'b0;
    logic [7:0] drv_a_val = 8'h00;
    logic       drv_b_en = 1'b0;
    logic       drv_b_val = 1'b0;

    tri   [7:0] bus_a;
    tri   [0:0] bus_b;

    logic        da_a, da_b;
    logic [15:0] enc_a, tog_a;
    logic [3:0]  enc_b, tog_b;

    int n_chk = 0;
    int n_fail = 0;

    assign bus_a = drv_a_en ? drv_a_val : 8'hzz;
    assign bus_b = drv_b_en ? drv_b_val : 1'bz;

    tri_buffer #(.WIDTH(8), .CNT_W(16)) dut_a (
        .d(d), .en(en), .y(bus_a), .clk(clk), .rst(rst),
        .drive_active(da_a), .en_cycles(enc_a), .d_toggles(tog_a)
    );

    tri_buffer #(.WIDTH(1), .CNT_W(4)) dut_b (
        .d(d[0]), .en(en), .y(bus_b), .clk(clk), .rst(rst),
        .drive_active(da_b), .en_cycles(enc_b), .d_toggles(tog_b)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int raw, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (raw > mx) ? mx : raw;
    endfunction

    // Model: raw event counts since the last reset edge, saturated only when compared
    bit         m_valid = 1'b0;
    logic       m_da = 1'b0;
    int         m_en_raw = 0;
    int         m_tog_a_raw = 0;
    int         m_tog_b_raw = 0;
    logic [7:0] m_prev = 8'h00;

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            m_valid     <= 1'b1;
            m_da        <= 1'b0;
            m_en_raw    <= 0;
            m_tog_a_raw <= 0;
            m_tog_b_raw <= 0;
            m_prev      <= 8'h00;
        end else begin
            m_da <= en;
            if (en === 1'b1) m_en_raw <= m_en_raw + 1;
            if (d !== m_prev) m_tog_a_raw <= m_tog_a_raw + 1;
            if (d[0] !== m_prev[0]) m_tog_b_raw <= m_tog_b_raw + 1;
            m_prev <= d;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("drive_active_a", {31'd0, da_a}, {31'd0, m_da});
            chk("drive_active_b", {31'd0, da_b}, {31'd0, m_da});
            chk("en_cycles_a", {16'd0, enc_a}, sat(m_en_raw, 16));
            chk("en_cycles_b", {28'd0, enc_b}, sat(m_en_raw, 4));
            chk("d_toggles_a", {16'd0, tog_a}, sat(m_tog_a_raw, 16));
            chk("d_toggles_b", {28'd0, tog_b}, sat(m_tog_b_raw, 4));
        end
    end

    initial begin
        logic [7:0] seq [5];
        seq[0] = 8'h00; seq[1] = 8'hA5; seq[2] = 8'hA5; seq[3] = 8'h00; seq[4] = 8'hA5;

        // Data path with the clock idle and reset never asserted
        en = 1'b1; d = 8'h01; #20;
        chk("y_a_en_d01", {24'd0, bus_a}, 32'h0000_00FE);
        chk("y_b_en_d1", {31'd0, bus_b}, 32'd0);
        d = 8'h00; #20;
        chk("y_a_en_d00", {24'd0, bus_a}, 32'h0000_00FF);
        chk("y_b_en_d0", {31'd0, bus_b}, 32'd1);
        en = 1'b0; drv_a_en = 1'b1; drv_a_val = 8'h00; drv_b_en = 1'b1; drv_b_val = 1'b0; #20;
        chk("release_a_d00", {24'd0, bus_a}, 32'h0000_0000);
        chk("release_b_d0", {31'd0, bus_b}, 32'd0);
        d = 8'h01; drv_a_val = 8'h01; #20;
        chk("release_a_d01", {24'd0, bus_a}, 32'h0000_0001);
        drv_a_en = 1'b0; drv_b_en = 1'b0; en = 1'b1; #1;
        chk("reenable_a", {24'd0, bus_a}, 32'h0000_00FE);
        chk("reenable_b", {31'd0, bus_b}, 32'd0);
        d = 8'hA5; #1;
        chk("y_a_A5", {24'd0, bus_a}, 32'h0000_005A);
        en = 1'b0; drv_a_en = 1'b1; drv_a_val = 8'h3C; #1;
        chk("release_a_A5", {24'd0, bus_a}, 32'h0000_003C);
        drv_a_en = 1'b0; en = 1'b0; d = 8'h00; #4;

        // Monitor: reset, then five enabled cycles
        clk_run = 1'b1; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rst_en_cycles", {16'd0, enc_a}, 32'd0);
        chk("rst_toggles", {16'd0, tog_a}, 32'd0);
        en = 1'b1;
        @(negedge clk);
        chk("da_rise", {31'd0, da_a}, 32'd1);
        repeat (4) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("en_cycles_5_a", {16'd0, enc_a}, 32'd5);
        chk("en_cycles_5_b", {28'd0, enc_b}, 32'd5);
        chk("da_fall", {31'd0, da_a}, 32'd0);

        // Toggle sequence 0,1,1,0,1 after reset
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = seq[i];
            @(negedge clk);
        end
        chk("toggles_3_a", {16'd0, tog_a}, 32'd3);
        chk("toggles_3_b", {28'd0, tog_b}, 32'd3);

        // Glitch between edges: y follows, monitor does not see it
        en = 1'b1; d = 8'h0F; #1;
        chk("glitch_y", {24'd0, bus_a}, 32'h0000_00F0);
        d = 8'hA5;
        @(negedge clk);
        chk("glitch_ignored", {16'd0, tog_a}, 32'd3);

        // Reset mid-count discards events on that edge
        d = 8'h00; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrst_en", {16'd0, enc_a}, 32'd0);
        chk("midrst_tog", {16'd0, tog_a}, 32'd0);
        chk("midrst_da", {31'd0, da_a}, 32'd0);

        // First edge after reset compares against zero
        d = 8'h5A; en = 1'b0;
        @(negedge clk);
        chk("first_edge_tog_a", {16'd0, tog_a}, 32'd1);
        chk("first_edge_tog_b", {28'd0, tog_b}, 32'd0);

        // Saturation of the 4-bit counters over 20 active, toggling cycles
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d = (i % 2 == 0) ? 8'hFF : 8'h00;
            @(negedge clk);
        end
        chk("sat_en_a", {16'd0, enc_a}, 32'd20);
        chk("sat_en_b", {28'd0, enc_b}, 32'd15);
        chk("sat_tog_a", {16'd0, tog_a}, 32'd20);
        chk("sat_tog_b", {28'd0, tog_b}, 32'd15);
        en = 1'b0;
        repeat (2) @(negedge clk);
        chk("sat_hold_b", {28'd0, enc_b}, 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
